ddr3_readback: RTL and testbench
================================

# ddr3_readback

Read-side companion to the DDR3 capture writer. Streams a requested number of fixed-length bursts out of one circular DDR3 region (CH1, CH2 or algorithm area) through the MIG user read port (rd_*_0), buffers the returned 128-bit beats in a local FIFO, and presents them as a valid/ready stream to the host uplink. It owns the read port that the writer leaves tied off, and shares the writer's address-map and burst-size constants.

## Interface
- RD_BASE_ADDR, 32'h80000000: first burst address of the region; the wrap target.
- RD_END_ADDR, 32'h9FFFFF80: last burst address of the region.
- BURST_RD_LENGTH, 128: beats per read command; driven on rd_len_0.
- ADDR_PACE, 128: address increment per completed burst.
- FIFO_DEPTH, 256: output buffer depth in beats; must be ≥ BURST_RD_LENGTH and a power of two.
- ddr3_user_clk  in  1  only clock.
- ddr3_ui_rst_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle request; ignored while busy.
- start_addr  in  32  first burst address; must be ADDR_PACE-aligned and inside [RD_BASE_ADDR, RD_END_ADDR].
- burst_count  in  20  number of bursts to read.
- abort  in  1  stops the transfer early.
- rd_addr_0  out  32  read command address.
- rd_len_0  out  20  constant BURST_RD_LENGTH.
- rd_valid_0  out  1  read command request.
- rd_ready_0  in  1  read command accept.
- rd_data_0  in  128  returned beat.
- rd_data_valid_0  in  1  beat qualifier.
- rd_data_end_0  in  1  last beat of the burst; qualified by rd_data_valid_0.
- out_data  out  128  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- len_err  out  1  sticky beat-count error; exists only when the check is enabled (see Configuration).

## Operation
- State machine:
  - IDLE:
    - start with burst_count == 0 goes to DONE.
    - start with burst_count ≠ 0 latches addr = start_addr and remaining = burst_count, then goes to CMD.
  - CMD:
    - rd_valid_0 = 1 when FIFO free space ≥ BURST_RD_LENGTH.
    - rd_valid_0 && rd_ready_0 goes to DATA.
    - abort goes to IDLE; no command has been issued.
  - DATA:
    - Each rd_data_valid_0 beat is written to the FIFO.
    - When rd_data_end_0 && rd_data_valid_0: remaining is decremented and addr advances.
    - Next state after the end beat:
      - remaining was 1: DONE.
      - abort has been latched: IDLE.
      - otherwise: CMD.
  - DONE: done = 1 for one cycle, then IDLE.
- At most one outstanding read command at any time.
- The credit check guarantees the FIFO never overflows. A push into a full FIFO is a design error, caught by an assertion.
- abort during DATA is latched. The current burst always completes and its data is delivered; no further commands follow. done is not pulsed on abort.
- Address wrap: next = (addr == RD_END_ADDR) ? RD_BASE_ADDR : addr + ADDR_PACE, computed in 32-bit arithmetic.
- busy = (state ≠ IDLE). The FIFO may still hold data after busy falls; it continues to drain to the stream.
- Stream: out_valid = FIFO not empty, first-word fall-through. A pop occurs on out_valid && out_ready. Back-pressure only delays the next command; no data is ever dropped.
- Beats arriving in IDLE (for example after a reset) are discarded.

## Timing
- Reset values:
  - rd_valid_0 = 0, rd_addr_0 = RD_BASE_ADDR.
  - out_valid = 0, busy = 0, done = 0, len_err = 0.
  - FIFO empty, state IDLE.
- Reset mid-transfer aborts immediately. Any in-flight beats from the DDR controller are then dropped in IDLE.
- start sampled at edge k: busy = 1 and rd_valid_0 = 1 from cycle k+1 (FIFO empty).
- rd_valid_0 and rd_addr_0 stay stable until accepted.
- rd_valid_0 falls in the cycle after acceptance.
- A beat written at edge k is visible on out_data/out_valid at cycle k+1.
- End beat at edge k:
  - Next rd_valid_0 at cycle k+1 at the earliest, with the advanced address.
  - Alternatively done = 1 at cycle k+1, and busy = 0 at k+2.
- A pop and a push in the same cycle keep the occupancy unchanged.

## Configuration
- RDBK_ERR_CHECK_EN defined:
  - A per-burst beat counter runs.
  - len_err sets, and stays set until reset, when an end beat arrives with count ≠ BURST_RD_LENGTH.
  - len_err also sets on a data beat received after the end beat but before the next command is accepted.
- RDBK_ERR_CHECK_EN undefined: no counter; len_err is tied to 0.

## Structure
- Package rdbk_pkg holds:
  - The state enum (IDLE, CMD, DATA, DONE).
  - The default region address constants and the burst length, shared with the writer.
- Sub-module rdbk_sync_fifo: single-clock FWFT FIFO, 128-bit wide, FIFO_DEPTH deep, with an occupancy count output used for the credit check.

## Test plan
- start, start_addr = 0x80000000, burst_count = 2, rd_ready_0 = 1, out_ready = 1 → two commands at 0x80000000 and 0x80000080, 256 beats out in order, then a single done pulse.
- start_addr = RD_END_ADDR, burst_count = 2 → second command at RD_BASE_ADDR.
- out_ready = 0 with FIFO_DEPTH = 256, burst_count = 3 → two bursts fetched, rd_valid_0 held low; raising out_ready lets the third issue once 128 slots are free; no data is lost.
- abort asserted mid-DATA on burst 1 of 4 → 128 beats delivered, no second command, busy falls, no done pulse.
- With RDBK_ERR_CHECK_EN, end beat on beat 127 → len_err = 1 and stays set until reset; without the macro, len_err = 0.
- Reset asserted mid-burst → all outputs at reset values the next cycle; trailing beats are ignored and out_valid stays 0.

Source files
------------

// File: rtl/rdbk_pkg.sv
// Shared constants, state encoding and address helper for the DDR3 readback path.
// Region map and burst size match the DDR3 capture writer.
package rdbk_pkg;

  localparam logic [31:0] RD_BASE_ADDR    = 32'h8000_0000;
  localparam logic [31:0] RD_END_ADDR     = 32'h9FFF_FF80;
  localparam int unsigned BURST_RD_LENGTH = 128;
  localparam logic [31:0] ADDR_PACE       = 32'd128;
  localparam int unsigned FIFO_DEPTH      = 256;
  localparam int unsigned DATA_W          = 128;
  localparam int unsigned CNT_W           = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rdbk_state_e;

  // Circular region: the last burst address wraps back to the base.
  function automatic logic [31:0] next_burst_addr(input logic [31:0] addr);
    return (addr == RD_END_ADDR) ? RD_BASE_ADDR : addr + ADDR_PACE;
  endfunction

endpackage

// File: rtl/ddr3_readback_if.sv
// MIG user read port (rd_*_0) plus the outbound valid/ready stream.
// master = readback engine, slave = MIG/host side.
interface ddr3_readback_if;
  import rdbk_pkg::*;

  logic [31:0]       rd_addr_0;
  logic [19:0]       rd_len_0;
  logic              rd_valid_0;
  logic              rd_ready_0;
  logic [DATA_W-1:0] rd_data_0;
  logic              rd_data_valid_0;
  logic              rd_data_end_0;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_addr_0, rd_len_0, rd_valid_0,
    input  rd_ready_0, rd_data_0, rd_data_valid_0, rd_data_end_0,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_addr_0, rd_len_0, rd_valid_0,
    output rd_ready_0, rd_data_0, rd_data_valid_0, rd_data_end_0,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/rdbk_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, DATA_W wide and FIFO_DEPTH deep.
// The occupancy count feeds the read-command credit check.
module rdbk_sync_fifo
  import rdbk_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  logic              push;
  logic              pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // The credit check upstream must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) wr_en |-> !full);

endmodule

// File: rtl/ddr3_readback.sv
// Streams burst_count fixed-length bursts from the circular DDR3 region out to the host.
// Optional build macro RDBK_ERR_CHECK_EN adds the sticky per-burst beat-count check (len_err).
//
// state | meaning
// IDLE  | waiting for start; stray beats are discarded
// CMD   | read command pending, raised once the FIFO has a full burst of space
// DATA  | command accepted, collecting beats until the end beat
// DONE  | one-cycle done pulse after the final burst
module ddr3_readback
  import rdbk_pkg::*;
(
  input  logic                  ddr3_user_clk,
  input  logic                  ddr3_ui_rst_n,
  input  logic                  start,
  input  logic [31:0]           start_addr,
  input  logic [19:0]           burst_count,
  input  logic                  abort,
  ddr3_readback_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err
);

  rdbk_state_e       state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [19:0]       remaining_q, remaining_d;
  logic              abort_q, abort_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_free;
  logic              fifo_empty;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              credit_ok;
  logic              rd_valid;
  logic              cmd_accept;
  logic              beat_in;
  logic              end_beat;
  logic              done_pulse;

  assign fifo_free  = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign credit_ok  = (fifo_free >= CNT_W'(BURST_RD_LENGTH));
  assign beat_in    = bus.rd_data_valid_0;
  assign end_beat   = beat_in && bus.rd_data_end_0;
  assign cmd_accept = (state_q == CMD) && rd_valid && bus.rd_ready_0;
  assign fifo_wr    = (state_q == DATA) && beat_in;
  assign fifo_rd    = !fifo_empty && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    abort_d     = abort_q;
    rd_valid    = 1'b0;
    done_pulse  = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          if (burst_count == 20'd0) begin
            state_d = DONE;
          end else begin
            addr_d      = start_addr;
            remaining_d = burst_count;
            state_d     = CMD;
          end
        end
      end
      CMD: begin
        rd_valid = credit_ok;
        // An accepted command wins over a same-cycle abort; the abort then waits for the burst.
        if (cmd_accept) begin
          abort_d = abort;
          state_d = DATA;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (abort) abort_d = 1'b1;
        if (end_beat) begin
          remaining_d = remaining_q - 20'd1;
          addr_d      = next_burst_addr(addr_q);
          if (remaining_q == 20'd1)   state_d = DONE;
          else if (abort_q || abort)  state_d = IDLE;
          else                        state_d = CMD;
        end
      end
      DONE: begin
        done_pulse = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_user_clk) begin
    if (!ddr3_ui_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= RD_BASE_ADDR;
      remaining_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      abort_q     <= abort_d;
    end
  end

  rdbk_sync_fifo u_fifo (
    .clk     (ddr3_user_clk),
    .rst_n   (ddr3_ui_rst_n),
    .wr_en   (fifo_wr),
    .wr_data (bus.rd_data_0),
    .rd_en   (fifo_rd),
    .rd_data (bus.out_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.rd_addr_0  = addr_q;
  assign bus.rd_len_0   = 20'(BURST_RD_LENGTH);
  assign bus.rd_valid_0 = rd_valid;
  assign bus.out_valid  = !fifo_empty;
  assign busy           = (state_q != IDLE);
  assign done           = done_pulse;

`ifdef RDBK_ERR_CHECK_EN
  localparam logic [7:0] BEAT_LAST = 8'(BURST_RD_LENGTH - 1);

  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       end_seen_q, end_seen_d;
  logic       len_err_q, len_err_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    end_seen_d = end_seen_q;
    len_err_d  = len_err_q;
    if (cmd_accept) begin
      beat_cnt_d = '0;
      end_seen_d = 1'b0;
    end else if (state_q == DATA && beat_in) begin
      if (bus.rd_data_end_0) begin
        if (beat_cnt_q != BEAT_LAST) len_err_d = 1'b1;
        end_seen_d = 1'b1;
        beat_cnt_d = '0;
      end else if (beat_cnt_q != 8'hFF) begin
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
    end else if (state_q == IDLE) begin
      end_seen_d = 1'b0;
    end
    // A beat after the end beat but before the next accept means the controller over-delivered.
    if (end_seen_q && beat_in && state_q != IDLE) len_err_d = 1'b1;
  end

  always_ff @(posedge ddr3_user_clk) begin
    if (!ddr3_ui_rst_n) begin
      beat_cnt_q <= '0;
      end_seen_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      end_seen_q <= end_seen_d;
      len_err_q  <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_readback.sv
// Scoreboard bench for ddr3_readback: a behavioural MIG read model feeds beats and
// queues the expected stream; a consumer pops and compares on every transfer.
module tb_ddr3_readback;
  import rdbk_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] LAST = 32'h9FFF_FF80;
`ifdef RDBK_ERR_CHECK_EN
  localparam bit EXP_LEN_ERR = 1'b1;
`else
  localparam bit EXP_LEN_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] start_addr;
  logic [19:0] burst_count;
  logic        busy;
  logic        done;
  logic        len_err;

  always #5 clk = ~clk;

  ddr3_readback_if bus();

  ddr3_readback dut (
    .ddr3_user_clk (clk),
    .ddr3_ui_rst_n (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .burst_count   (burst_count),
    .abort         (abort),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .len_err       (len_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0]  exp_addr_q [$];
  logic [127:0] exp_data_q [$];
  logic [31:0]  pend_addr [$];
  bit           burst_act = 1'b0;
  logic [31:0]  cur_addr;
  int           beat_idx = 0;
  int           cur_len = 0;
  int           burst_seq = 0;
  int           cmd_cnt = 0;
  int           beats_out = 0;
  int           done_cnt = 0;
  bit           expect_push = 1'b1;
  bit           short_burst = 1'b0;

  function automatic logic [127:0] beat_word(input logic [31:0] a, input int idx, input int seq);
    return {a, 32'(idx), 32'(seq), ~a};
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] a);
    return (a == LAST) ? BASE : a + 32'h80;
  endfunction

  // MIG read model: one beat per cycle with random gaps, command seen at negedge is accepted at the next posedge.
  always @(negedge clk) begin
    bus.rd_data_valid_0 = 1'b0;
    bus.rd_data_end_0   = 1'b0;
    if (!burst_act && pend_addr.size() != 0) begin
      cur_addr  = pend_addr.pop_front();
      burst_act = 1'b1;
      beat_idx  = 0;
      cur_len   = short_burst ? 127 : 128;
      burst_seq++;
    end
    if (burst_act && $urandom_range(0, 4) != 0) begin
      bus.rd_data_valid_0 = 1'b1;
      bus.rd_data_0       = beat_word(cur_addr, beat_idx, burst_seq);
      bus.rd_data_end_0   = (beat_idx == cur_len - 1);
      if (expect_push) exp_data_q.push_back(bus.rd_data_0);
      beat_idx++;
      if (beat_idx == cur_len) burst_act = 1'b0;
    end
    if (bus.rd_valid_0 && bus.rd_ready_0) begin
      cmd_cnt++;
      check_eq("outstanding", 32'(pend_addr.size()) + 32'(burst_act), 0);
      check_eq("rd_len", bus.rd_len_0, 128);
      if (exp_addr_q.size() == 0) check_eq("cmd_extra", 32'(exp_addr_q.size()), 1);
      else                        check_eq("cmd_addr", bus.rd_addr_0, exp_addr_q.pop_front());
      pend_addr.push_back(bus.rd_addr_0);
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      beats_out++;
      if (exp_data_q.size() == 0) check_eq("out_extra", 32'(exp_data_q.size()), 1);
      else                        check_eq("out_data", bus.out_data, exp_data_q.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_addrs(input logic [31:0] a, input int n);
    logic [31:0] x = a;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(x);
      x = ref_next(x);
    end
  endtask

  task automatic run_start(input string tag, input logic [31:0] a, input logic [19:0] n);
    start_addr  = a;
    burst_count = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    check_eq({tag, "_busy_k1"}, busy, 1);
    check_eq({tag, "_rdv_k1"}, bus.rd_valid_0, 1);
    check_eq({tag, "_addr_k1"}, bus.rd_addr_0, a);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy_at_done"}, busy, 1);
    tick();
    check_eq({tag, "_done_width"}, done, 0);
    check_eq({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic wait_quiet(input string tag, input int limit);
    int n = 0;
    while ((busy || burst_act || pend_addr.size() != 0 || bus.out_valid) && n < limit) begin
      tick();
      n++;
    end
    check_eq({tag, "_quiet"}, {busy, burst_act, (pend_addr.size() != 0), bus.out_valid}, 0);
  endtask

  task automatic wait_mid_burst(input string tag);
    int n = 0;
    while (!(burst_act && beat_idx >= 40) && n < 1000) begin
      tick();
      n++;
    end
    check_eq({tag, "_mid_burst"}, (burst_act && beat_idx >= 40), 1);
  endtask

  int c0, b0, d0;
  bit ov_seen;

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    start_addr     = '0;
    burst_count    = '0;
    bus.rd_ready_0 = 1'b1;
    bus.out_ready  = 1'b1;
    tick(3);
    check_eq("rst_rd_valid", bus.rd_valid_0, 0);
    check_eq("rst_rd_addr", bus.rd_addr_0, BASE);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_len_err", len_err, 0);
    rst_n = 1'b1;
    tick(2);

    // Two bursts from the base address.
    c0 = cmd_cnt; b0 = beats_out; d0 = done_cnt;
    push_addrs(BASE, 2);
    run_start("t1", BASE, 20'd2);
    wait_done("t1", 2000);
    wait_quiet("t1", 500);
    check_eq("t1_cmds", cmd_cnt - c0, 2);
    check_eq("t1_beats", beats_out - b0, 256);
    check_eq("t1_done_cnt", done_cnt - d0, 1);
    check_eq("t1_exp_left", exp_data_q.size() + exp_addr_q.size(), 0);

    // Wrap from the last burst address back to the base.
    c0 = cmd_cnt; b0 = beats_out;
    push_addrs(LAST, 2);
    run_start("t2", LAST, 20'd2);
    wait_done("t2", 2000);
    wait_quiet("t2", 500);
    check_eq("t2_cmds", cmd_cnt - c0, 2);
    check_eq("t2_beats", beats_out - b0, 256);

    // Back-pressure: two bursts fill the FIFO, the third waits for space.
    c0 = cmd_cnt; b0 = beats_out;
    bus.out_ready = 1'b0;
    push_addrs(BASE + 32'h100, 3);
    run_start("t3", BASE + 32'h100, 20'd3);
    tick(500);
    check_eq("t3_cmds_held", cmd_cnt - c0, 2);
    check_eq("t3_rdv_low", bus.rd_valid_0, 0);
    check_eq("t3_out_valid", bus.out_valid, 1);
    check_eq("t3_busy", busy, 1);
    bus.out_ready = 1'b1;
    wait_done("t3", 3000);
    wait_quiet("t3", 500);
    check_eq("t3_cmds", cmd_cnt - c0, 3);
    check_eq("t3_beats", beats_out - b0, 384);

    // Abort during the first of four bursts.
    c0 = cmd_cnt; b0 = beats_out; d0 = done_cnt;
    push_addrs(BASE, 1);
    run_start("t4", BASE, 20'd4);
    wait_mid_burst("t4");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_quiet("t4", 2000);
    tick(50);
    check_eq("t4_cmds", cmd_cnt - c0, 1);
    check_eq("t4_beats", beats_out - b0, 128);
    check_eq("t4_no_done", done_cnt - d0, 0);
    check_eq("t4_busy", busy, 0);

    // Short burst: end beat on beat 127.
    c0 = cmd_cnt; b0 = beats_out;
    short_burst = 1'b1;
    push_addrs(BASE + 32'h80, 1);
    run_start("t5", BASE + 32'h80, 20'd1);
    wait_done("t5", 1000);
    wait_quiet("t5", 500);
    short_burst = 1'b0;
    check_eq("t5_beats", beats_out - b0, 127);
    check_eq("t5_len_err", len_err, EXP_LEN_ERR);
    push_addrs(BASE, 1);
    run_start("t5b", BASE, 20'd1);
    wait_done("t5b", 1000);
    wait_quiet("t5b", 500);
    check_eq("t5b_len_err_sticky", len_err, EXP_LEN_ERR);

    // Reset in the middle of a burst; trailing beats must be dropped.
    c0 = cmd_cnt;
    push_addrs(BASE, 2);
    run_start("t6", BASE, 20'd2);
    wait_mid_burst("t6");
    bus.out_ready = 1'b0;
    tick();
    rst_n       = 1'b0;
    expect_push = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();
    tick();
    check_eq("t6_rd_valid", bus.rd_valid_0, 0);
    check_eq("t6_rd_addr", bus.rd_addr_0, BASE);
    check_eq("t6_out_valid", bus.out_valid, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_done", done, 0);
    check_eq("t6_len_err", len_err, 0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    ov_seen       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      ov_seen = ov_seen | bus.out_valid;
    end
    check_eq("t6_trailing_dropped", ov_seen, 0);
    check_eq("t6_cmds", cmd_cnt - c0, 1);
    check_eq("t6_model_idle", burst_act, 0);
    expect_push = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
